serial_tx: RTL and testbench
============================

# serial_tx

UART transmitter for the clk74 domain: 8N1 at 115200 baud by default, LSB first, idle-high line. Bytes are queued in a small internal FIFO so a host FSM can post short bursts without waiting on the line. It is the transmit-side counterpart of the `serial` receiver and shares its bit-period constant, so a loopback of `tx` into `serial.rx` at the same RCONST reproduces the sent bytes.

## Interface
- RCONST, 642, bit period minus one, in clk74 cycles; each bit lasts RCONST+1 cycles.
- FIFO_AW, 2, FIFO address width; depth = 2**FIFO_AW (4 entries).
- clk74  input  1  system clock.
- reset  input  1  asynchronous, active-high.
- tx_byte  input  8  data to queue; sampled when tx_load=1.
- tx_load  input  1  one-cycle write strobe.
- tx  output  1  serial line; idle high.
- tx_busy  output  1  high while state≠IDLE or FIFO not empty.
- tx_full  output  1  FIFO holds 2**FIFO_AW entries.
- tx_drop  output  1  one-cycle pulse: tx_load arrived while full, byte discarded.

## Operation
- Reset values: tx=1, tx_busy=0, tx_full=0, tx_drop=0, FIFO empty, state IDLE, bit counter 0.
- FIFO: read/write pointers are FIFO_AW+1 bits wide; occupancy = wr−rd mod 2**(FIFO_AW+1).
- A write is accepted at edge N if tx_load=1 and tx_full=0 before edge N. A write and a pop at the same edge are both performed.
- Full status is the pre-edge value: a load at a full FIFO is dropped even if a pop occurs on the same edge. tx_drop=1 for the cycle after that edge.
- No bypass path: a byte always passes through the FIFO.
- FSM states: IDLE, START, DATA, STOP (PARITY only with the macro).
- IDLE: if the FIFO is non-empty at an edge, pop the head into the shift register, set tx<=0, clear the baud counter, and go to START.
- Baud counter counts 0..RCONST. The bit ends at the edge where cnt==RCONST, and the counter then wraps to 0.
- START: at the end of the bit, tx<=shift[0] and go to DATA with bit index 0.
- DATA: at the end of each bit, shift right and output the next bit. After bit 7 completes, go to STOP with tx<=1.
- STOP: at the end of the bit, if the FIFO is non-empty, pop and go directly to START with tx<=0 (no idle gap). Otherwise go to IDLE with tx staying 1.
- Reset mid-frame: tx returns to 1 asynchronously, the FIFO is flushed, and the partial frame is abandoned.

## Timing
- tx_load sampled at edge N into an empty FIFO while IDLE:
  - tx_busy=1 after edge N.
  - tx falls at edge N+1.
  - The start bit spans edges N+1..N+1+RCONST.
- Each bit is exactly RCONST+1 cycles. The 8N1 frame is 10·(RCONST+1) cycles. Back-to-back frames abut with no extra cycles.
- tx_full and tx_busy are derived from registered state and pointers (no combinational path from tx_load).
- tx_busy falls at the edge that returns to IDLE with the FIFO empty.

## Configuration
- SERIAL_TX_PARITY_EN defined:
  - After DATA, a PARITY state transmits one even-parity bit (XOR of the 8 data bits) for RCONST+1 cycles, then goes to STOP.
  - The frame is 11 bits (8E1), 11·(RCONST+1) cycles.
- SERIAL_TX_PARITY_EN undefined: no PARITY state or logic; the frame is 8N1. Use this mode with the `serial` receiver.

## Test plan
- Single byte, RCONST=9, tx_load at edge N with 0x55:
  - tx=0 over edges N+1..N+10.
  - Data bits 1,0,1,0,1,0,1,0 for 10 cycles each.
  - Stop bit high for 10 cycles.
  - tx_busy falls at edge N+101.
- Back-to-back, RCONST=9: load 0x01, 0x80, 0xFF on consecutive cycles → three contiguous 100-cycle frames with no idle cycles between them; tx_busy stays high for 300 cycles.
- Overflow, RCONST=9, FIFO_AW=2: tx_load on 6 consecutive edges with bytes 0x10..0x15:
  - 0x10..0x14 are sent in order.
  - 0x15 is dropped; tx_drop pulses once after the 6th edge.
  - tx_full=1 after the 5th load.
- Reset mid-frame: assert reset during DATA bit 3 with 2 bytes queued → tx=1 immediately, tx_busy=0, and nothing is transmitted after release until a new tx_load.
- Loopback, RCONST=642: tx wired to `serial.rx`, send 0xA5 then 0x3C → rx_byte=0xA5 then 0x3C, with one rbyte_ready pulse per byte.
- With SERIAL_TX_PARITY_EN, RCONST=9: send 0x07 → parity bit 1 and frame length 110 cycles. Send 0x03 → parity bit 0.

Source files
------------

// File: rtl/serial_tx_if.sv
// ============================================================================
// Module      : serial_tx_if
// Description : Host-side transmit bus for serial_tx. The master modport is
//               the host posting bytes; the slave modport is the transmitter.
//               Signals:
//                 tx_byte  8  data to queue, sampled when tx_load=1
//                 tx_load  1  one-cycle write strobe
//                 tx       1  serial line, idle high
//                 tx_busy  1  frame in progress or bytes still queued
//                 tx_full  1  FIFO full
//                 tx_drop  1  one-cycle pulse: a load was discarded (full)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface serial_tx_if;
    logic [7:0] tx_byte;
    logic       tx_load;
    logic       tx;
    logic       tx_busy;
    logic       tx_full;
    logic       tx_drop;

    modport master (
        output tx_byte,
        output tx_load,
        input  tx,
        input  tx_busy,
        input  tx_full,
        input  tx_drop
    );

    modport slave (
        input  tx_byte,
        input  tx_load,
        output tx,
        output tx_busy,
        output tx_full,
        output tx_drop
    );
endinterface

`default_nettype wire

// File: rtl/serial_tx.sv
// ============================================================================
// Module      : serial_tx
// Description : UART transmitter, 8N1, LSB first, idle-high line. Bytes are
//               posted into a 2**FIFO_AW entry FIFO and sent back to back
//               with no idle gap between frames. Bit period is RCONST+1
//               clk74 cycles, matching the `serial` receiver.
//               Optional feature macro: SERIAL_TX_PARITY_EN adds an even
//               parity bit after the data bits (8E1 frame).
// Ports       : clk74  - system clock
//               reset  - asynchronous, active-high
//               bus    - serial_tx_if.slave (tx_byte, tx_load, tx, tx_busy,
//                        tx_full, tx_drop)
// Parameters  : RCONST  - bit period minus one, in clk74 cycles
//               FIFO_AW - FIFO address width (depth 2**FIFO_AW), >= 1
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_tx #(
    parameter int RCONST  = 642,
    parameter int FIFO_AW = 2
) (
    input  wire logic   clk74,
    input  wire logic   reset,
    serial_tx_if.slave  bus
);

    localparam int c_DEPTH = 1 << FIFO_AW;
    localparam int c_CW    = (RCONST < 1) ? 1 : $clog2(RCONST + 1);
    localparam logic [c_CW-1:0] c_RMAX = c_CW'(RCONST);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd3
`ifdef SERIAL_TX_PARITY_EN
        ,
        S_PARITY = 3'd4
`endif
    } state_t;

    // ------------------------------------------------------------------
    // FIFO: pointers carry one extra wrap bit so full and empty are
    // distinguishable without a separate occupancy counter.
    // ------------------------------------------------------------------
    logic [7:0]       r_mem [0:c_DEPTH-1];
    logic [FIFO_AW:0] r_wr;
    logic [FIFO_AW:0] r_rd;
    logic             w_empty;
    logic             w_full;
    logic             w_push;
    logic             w_pop;
    logic [7:0]       w_head;
    logic             r_drop;

    assign w_empty = (r_wr == r_rd);
    assign w_full  = (r_wr[FIFO_AW] != r_rd[FIFO_AW]) &&
                     (r_wr[FIFO_AW-1:0] == r_rd[FIFO_AW-1:0]);
    // Full is judged on the pre-edge pointers, so a pop on the same edge
    // does not rescue a load into a full FIFO.
    assign w_push  = bus.tx_load && !w_full;
    assign w_head  = r_mem[r_rd[FIFO_AW-1:0]];

    always_ff @(posedge clk74) begin
        if (w_push) begin
            r_mem[r_wr[FIFO_AW-1:0]] <= bus.tx_byte;
        end
    end

    always_ff @(posedge clk74 or posedge reset) begin
        if (reset) begin
            r_wr   <= '0;
            r_rd   <= '0;
            r_drop <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr <= r_wr + 1'b1;
            end
            if (w_pop) begin
                r_rd <= r_rd + 1'b1;
            end
            r_drop <= bus.tx_load && w_full;
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    state_t          r_state;
    state_t          w_state_nx;
    logic [c_CW-1:0] r_cnt;
    logic [c_CW-1:0] w_cnt_nx;
    logic [2:0]      r_bit;
    logic [2:0]      w_bit_nx;
    logic [7:0]      r_shift;
    logic [7:0]      w_shift_nx;
    logic            r_tx;
    logic            w_tx_nx;
    logic            w_bit_end;

    assign w_bit_end = (r_cnt == c_RMAX);

`ifdef SERIAL_TX_PARITY_EN
    logic r_par;
    logic w_par_nx;
`endif

    always_ff @(posedge clk74 or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
`ifdef SERIAL_TX_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_bit   <= w_bit_nx;
            r_shift <= w_shift_nx;
            r_tx    <= w_tx_nx;
`ifdef SERIAL_TX_PARITY_EN
            r_par   <= w_par_nx;
`endif
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = w_bit_end ? '0 : r_cnt + 1'b1;
        w_bit_nx   = r_bit;
        w_shift_nx = r_shift;
        w_tx_nx    = r_tx;
        w_pop      = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
        w_par_nx   = r_par;
`endif

        case (r_state)
            S_IDLE: begin
                // Hold the counter at zero so the start bit is full length.
                w_cnt_nx = '0;
                if (!w_empty) begin
                    w_pop      = 1'b1;
                    w_shift_nx = w_head;
                    w_tx_nx    = 1'b0;
                    w_state_nx = S_START;
`ifdef SERIAL_TX_PARITY_EN
                    w_par_nx   = ^w_head;
`endif
                end
            end

            S_START: begin
                if (w_bit_end) begin
                    w_tx_nx    = r_shift[0];
                    w_bit_nx   = 3'd0;
                    w_state_nx = S_DATA;
                end
            end

            S_DATA: begin
                if (w_bit_end) begin
                    if (r_bit == 3'd7) begin
`ifdef SERIAL_TX_PARITY_EN
                        w_tx_nx    = r_par;
                        w_state_nx = S_PARITY;
`else
                        w_tx_nx    = 1'b1;
                        w_state_nx = S_STOP;
`endif
                    end else begin
                        // shift[1] becomes shift[0] at this edge.
                        w_tx_nx    = r_shift[1];
                        w_shift_nx = {1'b0, r_shift[7:1]};
                        w_bit_nx   = r_bit + 3'd1;
                    end
                end
            end

`ifdef SERIAL_TX_PARITY_EN
            S_PARITY: begin
                if (w_bit_end) begin
                    w_tx_nx    = 1'b1;
                    w_state_nx = S_STOP;
                end
            end
`endif

            S_STOP: begin
                if (w_bit_end) begin
                    if (!w_empty) begin
                        // Chain straight into the next start bit.
                        w_pop      = 1'b1;
                        w_shift_nx = w_head;
                        w_tx_nx    = 1'b0;
                        w_state_nx = S_START;
`ifdef SERIAL_TX_PARITY_EN
                        w_par_nx   = ^w_head;
`endif
                    end else begin
                        w_state_nx = S_IDLE;
                    end
                end
            end

            default: begin
                w_state_nx = S_IDLE;
                w_tx_nx    = 1'b1;
            end
        endcase
    end

    assign bus.tx      = r_tx;
    assign bus.tx_busy = (r_state != S_IDLE) || !w_empty;
    assign bus.tx_full = w_full;
    assign bus.tx_drop = r_drop;

endmodule

`default_nettype wire

// File: tb/tb_serial_tx.sv
// ============================================================================
// Module      : tb_serial_tx
// Description : Self-checking bench for serial_tx at RCONST=9, FIFO_AW=2.
//               A line monitor rebuilds each expected frame from a
//               scoreboard queue and checks tx on every cycle of the frame.
//               Honors SERIAL_TX_PARITY_EN (8E1 frame) when defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_tx;

    localparam int R    = 9;
    localparam int AW   = 2;
    localparam int BITP = R + 1;
`ifdef SERIAL_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * BITP;

    logic clk74 = 1'b0;
    logic reset;

    serial_tx_if bus ();

    serial_tx #(.RCONST(R), .FIFO_AW(AW)) dut (
        .clk74 (clk74),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk74 = ~clk74;

    int n_vec = 0;
    int n_err = 0;
    int frames_done = 0;

    logic [7:0] sb_q [$];

    typedef struct {
        logic [7:0] data;
        logic       exp_d0;
        logic       exp_d7;
        logic       exp_par;
    } vec_t;

    vec_t tbl [0:7];

    task automatic tick();
        @(posedge clk74);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic load(input logic [7:0] d, input bit accept);
        bus.tx_byte = d;
        bus.tx_load = 1'b1;
        if (accept) sb_q.push_back(d);
        tick();
        bus.tx_load = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc, input string name);
        int k = 0;
        while (bus.tx_busy && k < max_cyc) begin
            tick();
            k++;
        end
        chk(name, bus.tx_busy, 0);
        tick();
    endtask

    // ------------------------------------------------------------------
    // Line monitor: once tx drops from idle, the whole frame is compared
    // cycle by cycle against the bits built from the next queued byte.
    // ------------------------------------------------------------------
    initial begin : monitor
        bit         m_active = 0;
        bit         m_orphan = 0;
        bit         m_bad    = 0;
        int         m_cyc    = 0;
        int         m_bad_cyc = 0;
        logic       m_bad_val = 1'b0;
        logic [7:0] m_exp    = 8'h00;
        logic [10:0] m_frame = '1;
        forever begin
            @(negedge clk74);
            if (reset) begin
                m_active = 0;
                m_orphan = 0;
            end else if (!m_active && bus.tx == 1'b0) begin
                m_active = 1;
                m_cyc    = 0;
                m_bad    = 0;
                m_frame  = '1;
                if (sb_q.size() == 0) begin
                    m_orphan = 1;
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_frame: actual start bit, required idle line");
                end else begin
                    m_exp = sb_q.pop_front();
                    m_frame[0] = 1'b0;
                    for (int i = 0; i < 8; i++) m_frame[1 + i] = m_exp[i];
`ifdef SERIAL_TX_PARITY_EN
                    m_frame[9] = ^m_exp;
`endif
                    m_frame[NBITS - 1] = 1'b1;
                end
            end
            if (m_active) begin
                if (!m_orphan && !m_bad && bus.tx !== m_frame[m_cyc / BITP]) begin
                    m_bad     = 1;
                    m_bad_cyc = m_cyc;
                    m_bad_val = bus.tx;
                end
                m_cyc++;
                if (m_cyc == FRAME) begin
                    if (!m_orphan) begin
                        n_vec++;
                        if (m_bad) begin
                            n_err++;
                            $display("FAIL frame_%02h: cycle %0d tx actual %b required %b",
                                     m_exp, m_bad_cyc, m_bad_val, m_frame[m_bad_cyc / BITP]);
                        end
                    end
                    frames_done++;
                    m_active = 0;
                    m_orphan = 0;
                end
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: actual timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        bit ok;
        reset       = 1'b1;
        bus.tx_load = 1'b0;
        bus.tx_byte = 8'h00;

        tbl[0] = '{8'h55, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{8'h00, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{8'hFF, 1'b1, 1'b1, 1'b0};
        tbl[3] = '{8'hA5, 1'b1, 1'b1, 1'b0};
        tbl[4] = '{8'h3C, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{8'h07, 1'b1, 1'b0, 1'b1};
        tbl[6] = '{8'h03, 1'b1, 1'b0, 1'b0};
        tbl[7] = '{8'h80, 1'b0, 1'b1, 1'b1};

        // Reset state
        repeat (3) tick();
        chk("rst_tx",   bus.tx,      1);
        chk("rst_busy", bus.tx_busy, 0);
        chk("rst_full", bus.tx_full, 0);
        chk("rst_drop", bus.tx_drop, 0);
        reset = 1'b0;
        repeat (2) tick();
        chk("post_rst_tx", bus.tx, 1);

        // Single-byte frames from the table
        foreach (tbl[i]) begin
            load(tbl[i].data, 1);                       // edge N
            chk("busy_after_load", bus.tx_busy, 1);
            chk("no_bypass_tx",    bus.tx,      1);
            tick();                                     // N+1
            chk("start_bit", bus.tx, 0);
            repeat (BITP) tick();                       // N+11
            chk("data_bit0", bus.tx, tbl[i].exp_d0);
            repeat (7 * BITP) tick();                   // N+81
            chk("data_bit7", bus.tx, tbl[i].exp_d7);
`ifdef SERIAL_TX_PARITY_EN
            repeat (BITP) tick();                       // N+91
            chk("parity_bit", bus.tx, tbl[i].exp_par);
            repeat (FRAME - 9 * BITP - 1) tick();       // N+FRAME
`else
            repeat (FRAME - 8 * BITP - 1) tick();       // N+FRAME
`endif
            chk("busy_last_cycle", bus.tx_busy, 1);
            tick();                                     // N+FRAME+1
            chk("busy_fall", bus.tx_busy, 0);
            tick();
        end

        // Back-to-back: three loads, three abutting frames
        load(8'h01, 1);                                 // edge N
        chk("b2b_busy_start", bus.tx_busy, 1);
        load(8'h80, 1);
        load(8'hFF, 1);                                 // edge N+2
        ok = 1;
        repeat (3 * FRAME - 2) begin
            tick();
            if (bus.tx_busy !== 1'b1) ok = 0;
        end
        chk("b2b_busy_held", ok, 1);
        tick();                                         // N+3*FRAME+1
        chk("b2b_busy_fall", bus.tx_busy, 0);
        tick();

        // Overflow: six loads into a four-entry FIFO (one popped early)
        load(8'h10, 1);
        load(8'h11, 1);
        load(8'h12, 1);
        load(8'h13, 1);
        chk("ovf_full_4", bus.tx_full, 0);
        load(8'h14, 1);
        chk("ovf_full_5", bus.tx_full, 1);
        chk("ovf_drop_5", bus.tx_drop, 0);
        load(8'h15, 0);
        chk("ovf_drop_6", bus.tx_drop, 1);
        chk("ovf_full_6", bus.tx_full, 1);
        tick();
        chk("ovf_drop_clear", bus.tx_drop, 0);
        wait_idle(6 * FRAME, "ovf_idle_bound");

        // Reset in data bit 3 with two bytes still queued
        load(8'hC1, 1);                                 // edge N, frame from N+1
        load(8'hC2, 0);
        load(8'hC3, 0);                                 // N+2
        repeat (44) tick();                             // N+46: data bit 3
        chk("pre_reset_bit3", bus.tx, 0);
        #1 reset = 1'b1;
        #1;
        chk("reset_async_tx",   bus.tx,      1);
        chk("reset_async_busy", bus.tx_busy, 0);
        chk("reset_async_full", bus.tx_full, 0);
        repeat (2) tick();
        reset = 1'b0;
        ok = 1;
        repeat (3 * FRAME) begin
            tick();
            if (bus.tx !== 1'b1 || bus.tx_busy !== 1'b0) ok = 0;
        end
        chk("reset_flushed_quiet", ok, 1);
        load(8'h5A, 1);
        wait_idle(2 * FRAME, "post_reset_idle_bound");

        chk("scoreboard_empty", sb_q.size(), 0);
        chk("frames_seen", frames_done, 17);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
